// File: rtl/riscv_pkg.sv
// Shared core-wide types and widths used by the memory port arbiter.
// Owner tags identify which core port a returning memory response belongs to.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int MEM_BE_W = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_LSU  = 2'd2
    } owner_e;

    typedef enum logic {
        PRIO_LSU = 1'b0,
        PRIO_IF  = 1'b1
    } arb_state_e;

    typedef struct packed {
        owner_e owner;
        logic   is_store;
    } resp_tag_t;

endpackage

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Delay line of response tags matching the fixed memory latency; the head
// names the requester whose read data is on mem_rdata_i this cycle.
module resp_tag_pipe
    import riscv_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] tail_owner,
    input  logic       tail_store,
    output logic [1:0] head_owner,
    output logic       head_store
);

    resp_tag_t stages [DEPTH];

    // NOTE: unlike a data RAM, every stage is reset: a stale owner left here
    // after reset would raise an rvalid for a request that no longer exists.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '{owner: OWNER_NONE, is_store: 1'b0};
            end
        end else begin
            stages[0] <= '{owner: owner_e'(tail_owner), is_store: tail_store};
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign head_owner = stages[DEPTH-1].owner;
    assign head_store = stages[DEPTH-1].is_store;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and LSU ports onto one fixed-latency memory port, LSU first,
// with a wait counter that forces IF through after bounded starvation.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                if_req_i,
    input  logic [XLEN-1:0]     if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [XLEN-1:0]     if_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [MEM_BE_W-1:0] lsu_be_i,
    input  logic [XLEN-1:0]     lsu_addr_i,
    input  logic [XLEN-1:0]     lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [XLEN-1:0]     lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [MEM_BE_W-1:0] mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic [XLEN-1:0]     mem_rdata_i
);

    localparam logic [4:0] WAIT_TRIP = 5'(MAX_WAIT - 1);
    localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);

    arb_state_e state, state_next;
    logic [3:0] wait_cnt;
    logic       if_win, lsu_win, if_denied;
    owner_e     tail_owner;
    logic [1:0] head_owner;
    logic       head_store;

    always_comb begin
        if_win     = 1'b0;
        lsu_win    = 1'b0;
        state_next = state;
        case (state)
            PRIO_LSU: begin
                lsu_win = lsu_req_i;
                if_win  = if_req_i & ~lsu_req_i;
            end
            PRIO_IF: begin
                if_win  = if_req_i;
                lsu_win = lsu_req_i & ~if_req_i;
            end
            default: ;
        endcase

        // Grants track the requests combinationally but stay low while in reset.
        if_gnt_o  = if_win & rstn_i;
        lsu_gnt_o = lsu_win & rstn_i;
        if_denied = if_req_i & ~if_gnt_o;

        // Flip priority on the denial that brings the count to MAX_WAIT-1,
        // so IF wins on its MAX_WAIT-th consecutive request cycle.
        case (state)
            PRIO_LSU: if (if_denied && (({1'b0, wait_cnt} + 5'd1) >= WAIT_TRIP)) state_next = PRIO_IF;
            PRIO_IF:  if (if_gnt_o) state_next = PRIO_LSU;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= PRIO_LSU;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (!if_req_i || if_gnt_o) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_SAT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        mem_req_o   = if_gnt_o | lsu_gnt_o;
        mem_we_o    = lsu_gnt_o & lsu_we_i;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        tail_owner  = OWNER_NONE;
        if (lsu_gnt_o) begin
            mem_be_o    = lsu_be_i;
            mem_addr_o  = lsu_addr_i;
            mem_wdata_o = lsu_wdata_i;
            tail_owner  = OWNER_LSU;
        end else if (if_gnt_o) begin
            mem_be_o   = {MEM_BE_W{1'b1}};
            mem_addr_o = if_addr_i;
            tail_owner = OWNER_IF;
        end
    end

    resp_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .tail_owner (tail_owner),
        .tail_store (lsu_gnt_o & lsu_we_i),
        .head_owner (head_owner),
        .head_store (head_store)
    );

    always_comb begin
        if_rvalid_o  = (head_owner == OWNER_IF);
        lsu_rvalid_o = (head_owner == OWNER_LSU);
        if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
        lsu_rdata_o  = (lsu_rvalid_o && !head_store) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-1 and a latency-3 instance share stimulus;
// a behavioural memory serves both and a scoreboard checks every response.
module tb_mem_port_arbiter;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [3:0]  lsu_be_i = 4'hF;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;

    logic        d1_if_gnt, d1_if_rvalid, d1_lsu_gnt, d1_lsu_rvalid, d1_mem_req, d1_mem_we;
    logic [31:0] d1_if_rdata, d1_lsu_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
    logic [3:0]  d1_mem_be;
    logic        d3_if_gnt, d3_if_rvalid, d3_lsu_gnt, d3_lsu_rvalid, d3_mem_req, d3_mem_we;
    logic [31:0] d3_if_rdata, d3_lsu_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;
    logic [3:0]  d3_mem_be;

    logic [31:0] mem [1024];
    logic        mem_init = 1'b0;
    logic [31:0] p1;
    logic [31:0] p3 [3];
    logic [31:0] cyc = '0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q_if1[$], q_lsu1[$], q_if3[$], q_lsu3[$];
    exp_t        e;
    logic        prev_rstn = 1'b0, prev_if_req = 1'b0, prev_if_gnt = 1'b0;
    logic        prev_lsu_req = 1'b0, prev_lsu_gnt = 1'b0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_WAIT(4)) dut1 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(d1_if_gnt),
        .if_rvalid_o(d1_if_rvalid), .if_rdata_o(d1_if_rdata),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(d1_lsu_gnt),
        .lsu_rvalid_o(d1_lsu_rvalid), .lsu_rdata_o(d1_lsu_rdata),
        .mem_req_o(d1_mem_req), .mem_we_o(d1_mem_we), .mem_be_o(d1_mem_be),
        .mem_addr_o(d1_mem_addr), .mem_wdata_o(d1_mem_wdata), .mem_rdata_i(d1_mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .MAX_WAIT(4)) dut3 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(d3_if_gnt),
        .if_rvalid_o(d3_if_rvalid), .if_rdata_o(d3_if_rdata),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(d3_lsu_gnt),
        .lsu_rvalid_o(d3_lsu_rvalid), .lsu_rdata_o(d3_lsu_rdata),
        .mem_req_o(d3_mem_req), .mem_we_o(d3_mem_we), .mem_be_o(d3_mem_be),
        .mem_addr_o(d3_mem_addr), .mem_wdata_o(d3_mem_wdata), .mem_rdata_i(d3_mem_rdata)
    );

    // Memory model: word i starts as {C0DE, i}; non-read cycles return junk.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= {16'hC0DE, 16'(i)};
            mem_init <= 1'b1;
        end else if (d1_mem_req && d1_mem_we) begin
            for (int b = 0; b < 4; b++)
                if (d1_mem_be[b]) mem[d1_mem_addr[11:2]][8*b +: 8] <= d1_mem_wdata[8*b +: 8];
        end
        p1    <= (d1_mem_req && !d1_mem_we) ? mem[d1_mem_addr[11:2]] : 32'hA5A5_A5A5;
        p3[0] <= (d3_mem_req && !d3_mem_we) ? mem[d3_mem_addr[11:2]] : 32'hA5A5_A5A5;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d1_mem_rdata = p1;
    assign d3_mem_rdata = p3[2];

    // Scoreboard monitor: pops/compares responses, then pushes new grants.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            q_if1.delete(); q_lsu1.delete(); q_if3.delete(); q_lsu3.delete();
        end else begin
            if (d1_if_rvalid) begin
                n_total++;
                if (q_if1.size() == 0) $display("FAIL d1_if_resp: unexpected rvalid rdata=%h at cyc %0d", d1_if_rdata, cyc);
                else begin
                    e = q_if1.pop_front();
                    if (d1_if_rdata !== e.data || cyc !== e.due)
                        $display("FAIL d1_if_resp: got %h at cyc %0d, expected %h at cyc %0d", d1_if_rdata, cyc, e.data, e.due);
                    else n_pass++;
                end
            end
            if (d1_lsu_rvalid) begin
                n_total++;
                if (q_lsu1.size() == 0) $display("FAIL d1_lsu_resp: unexpected rvalid rdata=%h at cyc %0d", d1_lsu_rdata, cyc);
                else begin
                    e = q_lsu1.pop_front();
                    if (d1_lsu_rdata !== e.data || cyc !== e.due)
                        $display("FAIL d1_lsu_resp: got %h at cyc %0d, expected %h at cyc %0d", d1_lsu_rdata, cyc, e.data, e.due);
                    else n_pass++;
                end
            end
            if (d3_if_rvalid) begin
                n_total++;
                if (q_if3.size() == 0) $display("FAIL d3_if_resp: unexpected rvalid rdata=%h at cyc %0d", d3_if_rdata, cyc);
                else begin
                    e = q_if3.pop_front();
                    if (d3_if_rdata !== e.data || cyc !== e.due)
                        $display("FAIL d3_if_resp: got %h at cyc %0d, expected %h at cyc %0d", d3_if_rdata, cyc, e.data, e.due);
                    else n_pass++;
                end
            end
            if (d3_lsu_rvalid) begin
                n_total++;
                if (q_lsu3.size() == 0) $display("FAIL d3_lsu_resp: unexpected rvalid rdata=%h at cyc %0d", d3_lsu_rdata, cyc);
                else begin
                    e = q_lsu3.pop_front();
                    if (d3_lsu_rdata !== e.data || cyc !== e.due)
                        $display("FAIL d3_lsu_resp: got %h at cyc %0d, expected %h at cyc %0d", d3_lsu_rdata, cyc, e.data, e.due);
                    else n_pass++;
                end
            end
            if (d3_if_rvalid || d3_lsu_rvalid) begin
                n_total++;
                if (d3_if_rvalid && d3_lsu_rvalid) $display("FAIL d3_dual_rvalid: both rvalids high at cyc %0d", cyc);
                else n_pass++;
            end
            n_total++;
            if ((!d1_if_rvalid && d1_if_rdata !== '0) || (!d1_lsu_rvalid && d1_lsu_rdata !== '0) ||
                (!d3_if_rvalid && d3_if_rdata !== '0) || (!d3_lsu_rvalid && d3_lsu_rdata !== '0))
                $display("FAIL idle_rdata: non-valid rdata not zero at cyc %0d (%h %h %h %h)",
                         cyc, d1_if_rdata, d1_lsu_rdata, d3_if_rdata, d3_lsu_rdata);
            else n_pass++;
            if (prev_rstn && ((prev_if_req && !prev_if_gnt && !if_req_i) || (prev_lsu_req && !prev_lsu_gnt && !lsu_req_i))) begin
                n_total++;
                $display("FAIL protocol: request dropped without grant at cyc %0d", cyc);
            end
            if (d1_if_gnt)  q_if1.push_back('{data: mem[if_addr_i[11:2]], due: cyc + 1});
            if (d1_lsu_gnt) q_lsu1.push_back('{data: lsu_we_i ? 32'h0 : mem[lsu_addr_i[11:2]], due: cyc + 1});
            if (d3_if_gnt)  q_if3.push_back('{data: mem[if_addr_i[11:2]], due: cyc + 3});
            if (d3_lsu_gnt) q_lsu3.push_back('{data: lsu_we_i ? 32'h0 : mem[lsu_addr_i[11:2]], due: cyc + 3});
        end
        prev_rstn    <= rstn_i;
        prev_if_req  <= if_req_i;
        prev_if_gnt  <= d1_if_gnt;
        prev_lsu_req <= lsu_req_i;
        prev_lsu_gnt <= d1_lsu_gnt;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((q_if1.size() + q_lsu1.size() + q_if3.size() + q_lsu3.size()) != 0 && k < 20) begin
            @(posedge clk_i);
            k++;
        end
        n_total++;
        if ((q_if1.size() + q_lsu1.size() + q_if3.size() + q_lsu3.size()) != 0)
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name,
                     q_if1.size() + q_lsu1.size() + q_if3.size() + q_lsu3.size());
        else n_pass++;
        step();
    endtask

    task automatic test_reset();
        if_req_i = 1'b1; lsu_req_i = 1'b1; lsu_addr_i = 32'h10; if_addr_i = 32'h0;
        @(negedge clk_i);
        n_total++;
        if ({d1_if_gnt, d1_lsu_gnt, d1_mem_req, d3_if_gnt, d3_lsu_gnt, d3_mem_req} !== 6'b0)
            $display("FAIL reset_gnt: grants/mem_req=%b, expected 000000",
                     {d1_if_gnt, d1_lsu_gnt, d1_mem_req, d3_if_gnt, d3_lsu_gnt, d3_mem_req});
        else n_pass++;
        n_total++;
        if ({d1_if_rvalid, d1_lsu_rvalid, d3_if_rvalid, d3_lsu_rvalid} !== 4'b0 ||
            (d1_if_rdata | d1_lsu_rdata | d3_if_rdata | d3_lsu_rdata) !== 32'h0)
            $display("FAIL reset_resp: rvalids=%b rdata or-ed=%h, expected 0",
                     {d1_if_rvalid, d1_lsu_rvalid, d3_if_rvalid, d3_lsu_rvalid},
                     d1_if_rdata | d1_lsu_rdata | d3_if_rdata | d3_lsu_rdata);
        else n_pass++;
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        step();
        rstn_i = 1'b1;
        @(negedge clk_i);
        n_total++;
        if ({d1_mem_req, d1_if_rvalid, d1_lsu_rvalid} !== 3'b0)
            $display("FAIL reset_release_idle: mem_req/rvalids=%b, expected 000", {d1_mem_req, d1_if_rvalid, d1_lsu_rvalid});
        else n_pass++;
        step();
    endtask

    task automatic test_if_only();
        if_req_i = 1'b1; if_addr_i = 32'h0;
        @(negedge clk_i);
        n_total++;
        if (d1_if_gnt !== 1'b1 || d1_lsu_gnt !== 1'b0 || d1_mem_addr !== 32'h0 ||
            d1_mem_be !== 4'hF || d1_mem_we !== 1'b0 || d1_mem_wdata !== 32'h0)
            $display("FAIL if_only_0: gnt=%b/%b addr=%h be=%h we=%b wdata=%h, expected 1/0 0 f 0 0",
                     d1_if_gnt, d1_lsu_gnt, d1_mem_addr, d1_mem_be, d1_mem_we, d1_mem_wdata);
        else n_pass++;
        step();
        if_addr_i = 32'h4;
        @(negedge clk_i);
        n_total++;
        if (d1_if_gnt !== 1'b1 || d1_mem_addr !== 32'h4 || d1_if_rvalid !== 1'b1 || d1_if_rdata !== 32'hC0DE_0000)
            $display("FAIL if_only_4: gnt=%b addr=%h rvalid=%b rdata=%h, expected 1 4 1 c0de0000",
                     d1_if_gnt, d1_mem_addr, d1_if_rvalid, d1_if_rdata);
        else n_pass++;
        step();
        if_req_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (d1_mem_req !== 1'b0 || d1_if_rvalid !== 1'b1 || d1_if_rdata !== 32'hC0DE_0001)
            $display("FAIL if_only_resp: mem_req=%b rvalid=%b rdata=%h, expected 0 1 c0de0001",
                     d1_mem_req, d1_if_rvalid, d1_if_rdata);
        else n_pass++;
        drain("if_only");
    endtask

    task automatic test_both_load();
        if_req_i = 1'b1; if_addr_i = 32'h8;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h100;
        @(negedge clk_i);
        n_total++;
        if (d1_lsu_gnt !== 1'b1 || d1_if_gnt !== 1'b0 || d1_mem_addr !== 32'h100 || d1_mem_we !== 1'b0)
            $display("FAIL both_load_gnt: lsu/if gnt=%b/%b addr=%h we=%b, expected 1/0 100 0",
                     d1_lsu_gnt, d1_if_gnt, d1_mem_addr, d1_mem_we);
        else n_pass++;
        step();
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (d1_if_gnt !== 1'b1 || d1_mem_addr !== 32'h8 || d1_lsu_rvalid !== 1'b1 || d1_lsu_rdata !== 32'hC0DE_0040)
            $display("FAIL both_load_next: if_gnt=%b addr=%h lsu_rvalid=%b rdata=%h, expected 1 8 1 c0de0040",
                     d1_if_gnt, d1_mem_addr, d1_lsu_rvalid, d1_lsu_rdata);
        else n_pass++;
        step();
        if_req_i = 1'b0;
        drain("both_load");
    endtask

    task automatic test_starvation();
        int j = 0;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'hF;
        lsu_addr_i = 32'h300; lsu_wdata_i = 32'h5000_0000;
        for (int k = 0; k < 8; k++) begin
            logic exp_if;
            exp_if = (k == 3) || (k == 7);
            @(negedge clk_i);
            n_total++;
            if (d1_if_gnt !== exp_if || d1_lsu_gnt !== !exp_if)
                $display("FAIL starve_k%0d: if/lsu gnt=%b/%b, expected %b/%b", k, d1_if_gnt, d1_lsu_gnt, exp_if, !exp_if);
            else n_pass++;
            step();
            if (exp_if) begin
                if_addr_i = if_addr_i + 32'h4;
                if (k == 7) if_req_i = 1'b0;
            end else begin
                j++;
                lsu_addr_i  = 32'h300 + 32'(4 * j);
                lsu_wdata_i = 32'h5000_0000 + 32'(j);
            end
        end
        @(negedge clk_i);
        n_total++;
        if (d1_lsu_gnt !== 1'b1) $display("FAIL starve_tail: lsu_gnt=%b, expected 1", d1_lsu_gnt);
        else n_pass++;
        step();
        lsu_req_i = 1'b0;
        drain("starve");
    endtask

    task automatic test_store();
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'b0011;
        lsu_addr_i = 32'h200; lsu_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        n_total++;
        if (d1_lsu_gnt !== 1'b1 || d1_mem_we !== 1'b1 || d1_mem_be !== 4'b0011 ||
            d1_mem_addr !== 32'h200 || d1_mem_wdata !== 32'hDEAD_BEEF)
            $display("FAIL store_mem: gnt=%b we=%b be=%b addr=%h wdata=%h, expected 1 1 0011 200 deadbeef",
                     d1_lsu_gnt, d1_mem_we, d1_mem_be, d1_mem_addr, d1_mem_wdata);
        else n_pass++;
        step();
        lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_wdata_i = 32'h0;
        @(negedge clk_i);
        n_total++;
        if (d1_lsu_rvalid !== 1'b1 || d1_lsu_rdata !== 32'h0 || d1_lsu_gnt !== 1'b1)
            $display("FAIL store_ack: rvalid=%b rdata=%h gnt=%b, expected 1 0 1", d1_lsu_rvalid, d1_lsu_rdata, d1_lsu_gnt);
        else n_pass++;
        step();
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (d1_lsu_rvalid !== 1'b1 || d1_lsu_rdata !== 32'hC0DE_BEEF)
            $display("FAIL store_readback: rvalid=%b rdata=%h, expected 1 c0debeef", d1_lsu_rvalid, d1_lsu_rdata);
        else n_pass++;
        drain("store");
    endtask

    task automatic test_back_to_back();
        lsu_we_i = 1'b0; lsu_be_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            if_req_i   = (k % 2 == 0);
            lsu_req_i  = (k % 2 == 1);
            if_addr_i  = 32'h20 + 32'(4 * k);
            lsu_addr_i = 32'h140 + 32'(4 * k);
            @(negedge clk_i);
            n_total++;
            if (d3_if_gnt !== (k % 2 == 0) || d3_lsu_gnt !== (k % 2 == 1))
                $display("FAIL b2b_k%0d: if/lsu gnt=%b/%b, expected %b/%b", k, d3_if_gnt, d3_lsu_gnt, k % 2 == 0, k % 2 == 1);
            else n_pass++;
            step();
        end
        if_req_i = 1'b0; lsu_req_i = 1'b0;
        drain("b2b");
    endtask

    task automatic test_reset_inflight();
        int j = 0;
        if_req_i = 1'b1; if_addr_i = 32'h40;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h180;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_total++;
            if (d1_lsu_gnt !== 1'b1 || d1_if_gnt !== 1'b0)
                $display("FAIL rst_pre_k%0d: lsu/if gnt=%b/%b, expected 1/0", k, d1_lsu_gnt, d1_if_gnt);
            else n_pass++;
            step();
            j++;
            lsu_addr_i = 32'h180 + 32'(4 * j);
        end
        rstn_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if ({d1_if_gnt, d1_lsu_gnt, d1_mem_req, d3_mem_req, d1_if_rvalid, d1_lsu_rvalid, d3_if_rvalid, d3_lsu_rvalid} !== 8'b0)
            $display("FAIL rst_mid: gnt/req/rvalid=%b, expected 00000000",
                     {d1_if_gnt, d1_lsu_gnt, d1_mem_req, d3_mem_req, d1_if_rvalid, d1_lsu_rvalid, d3_if_rvalid, d3_lsu_rvalid});
        else n_pass++;
        step();
        rstn_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_if;
            exp_if = (k == 3);
            @(negedge clk_i);
            n_total++;
            if (d1_if_gnt !== exp_if || d1_lsu_gnt !== !exp_if || d3_if_gnt !== exp_if)
                $display("FAIL rst_post_k%0d: if/lsu gnt=%b/%b d3_if=%b, expected %b/%b", k,
                         d1_if_gnt, d1_lsu_gnt, d3_if_gnt, exp_if, !exp_if);
            else n_pass++;
            if (k < 2) begin
                n_total++;
                if ({d1_if_rvalid, d1_lsu_rvalid, d3_if_rvalid, d3_lsu_rvalid} !== 4'b0 && k == 0)
                    $display("FAIL rst_stale: rvalids=%b after release, expected 0000",
                             {d1_if_rvalid, d1_lsu_rvalid, d3_if_rvalid, d3_lsu_rvalid});
                else if ({d3_if_rvalid, d3_lsu_rvalid} !== 2'b0)
                    $display("FAIL rst_stale_d3: rvalids=%b after release, expected 00", {d3_if_rvalid, d3_lsu_rvalid});
                else n_pass++;
            end
            step();
            if (exp_if) if_req_i = 1'b0;
            else begin
                j++;
                lsu_addr_i = 32'h180 + 32'(4 * j);
            end
        end
        @(negedge clk_i);
        n_total++;
        if (d1_lsu_gnt !== 1'b1) $display("FAIL rst_tail: lsu_gnt=%b, expected 1", d1_lsu_gnt);
        else n_pass++;
        step();
        lsu_req_i = 1'b0;
        drain("rst_inflight");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_if_only();
        test_both_load();
        test_starvation();
        test_store();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
